// File: rtl/uart_pkg.sv
// uart_pkg: shared opcodes, default widths and FSM state encoding for the UART command controller.
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_RD_TIMEOUT = 16;
    localparam logic [7:0] DEF_WR_CMD = 8'hAA;
    localparam logic [7:0] DEF_RD_CMD = 8'hBB;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_TX_SEND = 3'd5;
endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// uart_rx_cmd_ctrl_if: RX byte stream, register-file access and TX byte signals of the command controller.
interface uart_rx_cmd_ctrl_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_d_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_vld;
    logic                  tx_busy;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_vld;
    logic                  cmd_err;
    modport master (
        output rx_p_data, rx_d_vld, rd_data, rd_data_vld, tx_busy,
        input  wr_en, rd_en, address, wr_data, tx_p_data, tx_d_vld, cmd_err
    );
    modport slave (
        input  rx_p_data, rx_d_vld, rd_data, rd_data_vld, tx_busy,
        output wr_en, rd_en, address, wr_data, tx_p_data, tx_d_vld, cmd_err
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: decodes {WR_CMD,addr,data} / {RD_CMD,addr} byte frames into register strobes
// and forwards read data to the UART transmitter.
module uart_rx_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = DEF_WR_CMD,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = DEF_RD_CMD,
    parameter int                    RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    uart_rx_cmd_ctrl_if.slave bus
);
    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);
    logic [2:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  err_q, err_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        txd_d    = txd_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        tx_vld_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.rx_d_vld) begin
                state_d = (bus.rx_p_data == WR_CMD) ? S_WR_ADDR :
                          (bus.rx_p_data == RD_CMD) ? S_RD_ADDR : S_IDLE;
                err_d   = (bus.rx_p_data != WR_CMD) && (bus.rx_p_data != RD_CMD);
            end
            S_WR_ADDR: if (bus.rx_d_vld) begin
                addr_d  = bus.rx_p_data[ADDR_WIDTH-1:0];
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (bus.rx_d_vld) begin
                wdata_d = bus.rx_p_data;
                wr_en_d = 1'b1;
                state_d = S_IDLE;
            end
            S_RD_ADDR: if (bus.rx_d_vld) begin
                addr_d  = bus.rx_p_data[ADDR_WIDTH-1:0];
                rd_en_d = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // bytes arriving while a read is outstanding are dropped and flagged
                err_d = bus.rx_d_vld;
                if (bus.rd_data_vld) begin
                    buf_d   = bus.rd_data;
                    state_d = S_TX_SEND;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_TX_SEND: begin
                err_d = bus.rx_d_vld;
                if (!bus.tx_busy) begin
                    tx_vld_d = 1'b1;
                    txd_d    = buf_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            txd_q    <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            txd_q    <= txd_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            tx_vld_q <= tx_vld_d;
            err_q    <= err_d;
        end
    end
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.address   = addr_q;
    assign bus.wr_data   = wdata_q;
    assign bus.tx_p_data = txd_q;
    assign bus.tx_d_vld  = tx_vld_q;
    assign bus.cmd_err   = err_q;
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb_uart_rx_cmd_ctrl: directed frame scenarios plus randomized traffic, checked every cycle
// against a frame-queue model of the command protocol.
module tb_uart_rx_cmd_ctrl;
    localparam int RD_TIMEOUT = 16;
    localparam logic [7:0] WR = 8'hAA;
    localparam logic [7:0] RD = 8'hBB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_cmd_ctrl_if bus ();
    uart_rx_cmd_ctrl #(.RD_TIMEOUT(RD_TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // register-file responder: answers rd_en after rd_delay cycles (0 = never)
    int rd_delay = 0;
    logic [7:0] rd_val = 8'h00;
    bit spur = 0;
    int rd_cnt = -1;
    always @(negedge clk) begin
        bus.rd_data_vld = 1'b0;
        if (rst) rd_cnt = -1;
        else if (bus.rd_en) rd_cnt = rd_delay - 1;
        if (rd_cnt == 0) begin
            bus.rd_data_vld = 1'b1;
            bus.rd_data     = rd_val;
            rd_cnt          = -1;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
        end else if (spur && $urandom_range(0, 15) == 0) begin
            bus.rd_data_vld = 1'b1;
            bus.rd_data     = 8'($urandom);
        end
    end

    // protocol model: bytes collect in a frame queue; an outstanding read and a pending tx byte are flags
    logic [7:0] frame[$];
    bit waiting, have_tx;
    int waited;
    logic [7:0] txbuf, m_txd, m_wdata;
    logic [3:0] m_addr;
    bit e_wr, e_rd, e_tx, e_err;
    always @(posedge clk) begin
        e_wr = 0; e_rd = 0; e_tx = 0; e_err = 0;
        if (rst) begin
            frame.delete();
            waiting = 0; have_tx = 0; waited = 0;
            txbuf = 0; m_txd = 0; m_wdata = 0; m_addr = 0;
        end else if (waiting) begin
            e_err = bus.rx_d_vld;
            if (bus.rd_data_vld) begin
                have_tx = 1; txbuf = bus.rd_data; waiting = 0;
            end else begin
                waited++;
                if (waited == RD_TIMEOUT) begin e_err = 1; waiting = 0; end
            end
        end else if (have_tx) begin
            e_err = bus.rx_d_vld;
            if (!bus.tx_busy) begin e_tx = 1; m_txd = txbuf; have_tx = 0; end
        end else if (bus.rx_d_vld) begin
            frame.push_back(bus.rx_p_data);
            if (frame[0] != WR && frame[0] != RD) begin
                e_err = 1; frame.delete();
            end else begin
                if (frame.size() == 2) m_addr = frame[1][3:0];
                if (frame[0] == WR && frame.size() == 3) begin
                    e_wr = 1; m_wdata = frame[2]; frame.delete();
                end else if (frame[0] == RD && frame.size() == 2) begin
                    e_rd = 1; waiting = 1; waited = 0; frame.delete();
                end
            end
        end
        #1;
        chk("m_wr_en", bus.wr_en, e_wr);
        chk("m_rd_en", bus.rd_en, e_rd);
        chk("m_tx_d_vld", bus.tx_d_vld, e_tx);
        chk("m_cmd_err", bus.cmd_err, e_err);
        chk("m_address", bus.address, m_addr);
        chk("m_wr_data", bus.wr_data, m_wdata);
        chk("m_tx_p_data", bus.tx_p_data, m_txd);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_d_vld  = 1'b1;
        bus.rx_p_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_d_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rx_d_vld = 0; bus.rx_p_data = 0; bus.tx_busy = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_tx_p_data", bus.tx_p_data, 0);
        @(negedge clk) rst = 0;

        // write frame
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        chk("t1_wr_en", bus.wr_en, 1);
        chk("t1_address", bus.address, 5);
        chk("t1_wr_data", bus.wr_data, 8'h3C);
        chk("t1_rd_en", bus.rd_en, 0);
        idle();
        chk("t1_wr_pulse", bus.wr_en, 0);

        // read frame, data after two cycles
        rd_delay = 2; rd_val = 8'hC3;
        send_byte(8'hBB); send_byte(8'h0A);
        chk("t2_rd_en", bus.rd_en, 1);
        chk("t2_address", bus.address, 4'hA);
        for (int k = 1; k <= 3; k++) begin
            idle();
            chk("t2_tx_d_vld", bus.tx_d_vld, k == 3);
        end
        chk("t2_tx_p_data", bus.tx_p_data, 8'hC3);

        // bad opcode, then truncated address
        send_byte(8'h7E);
        chk("t3_cmd_err", bus.cmd_err, 1);
        chk("t3_no_wr", bus.wr_en, 0);
        send_byte(8'hAA); send_byte(8'hFF); send_byte(8'h11);
        chk("t3_wr_en", bus.wr_en, 1);
        chk("t3_address", bus.address, 4'hF);
        chk("t3_wr_data", bus.wr_data, 8'h11);

        // read timeout
        rd_delay = 0;
        send_byte(8'hBB); send_byte(8'h0B);
        for (int k = 1; k <= RD_TIMEOUT; k++) begin
            idle();
            chk("t4_timeout_err", bus.cmd_err, k == RD_TIMEOUT);
        end
        // data on the expiry cycle wins
        rd_delay = RD_TIMEOUT; rd_val = 8'h96;
        send_byte(8'hBB); send_byte(8'h0C);
        for (int k = 1; k <= RD_TIMEOUT + 1; k++) begin
            idle();
            chk("t4b_no_err", bus.cmd_err, 0);
        end
        chk("t4b_tx_d_vld", bus.tx_d_vld, 1);
        chk("t4b_tx_p_data", bus.tx_p_data, 8'h96);

        // tx_busy hold with a stray byte
        @(negedge clk) bus.tx_busy = 1;
        rd_delay = 2; rd_val = 8'h5A;
        send_byte(8'hBB); send_byte(8'h01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.rx_d_vld  = (i == 5);
            bus.rx_p_data = 8'h55;
            @(posedge clk);
            #1;
            chk("t5_tx_held", bus.tx_d_vld, 0);
            if (i == 5) begin
                chk("t5_cmd_err", bus.cmd_err, 1);
                chk("t5_tx_p_data_kept", bus.tx_p_data, 8'h96);
            end
        end
        @(negedge clk);
        bus.tx_busy = 0; bus.rx_d_vld = 0;
        @(posedge clk);
        #1;
        chk("t5_tx_d_vld", bus.tx_d_vld, 1);
        chk("t5_tx_p_data", bus.tx_p_data, 8'h5A);
        idle();
        chk("t5_tx_pulse", bus.tx_d_vld, 0);

        // reset mid-frame
        send_byte(8'hAA); send_byte(8'h03);
        chk("t6_addr_before", bus.address, 3);
        @(negedge clk);
        bus.rx_d_vld = 0; rst = 1;
        #1;
        chk("t6_rst_address", bus.address, 0);
        chk("t6_rst_tx_p_data", bus.tx_p_data, 0);
        chk("t6_rst_wr_data", bus.wr_data, 0);
        @(negedge clk) rst = 0;
        send_byte(8'h44);
        chk("t6_cmd_err", bus.cmd_err, 1);
        chk("t6_no_wr", bus.wr_en, 0);
        idle();

        // randomized traffic
        spur = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.rx_d_vld = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: bus.rx_p_data = WR;
                3, 4:    bus.rx_p_data = RD;
                default: bus.rx_p_data = 8'($urandom);
            endcase
            bus.tx_busy = ($urandom_range(0, 2) == 0);
            rd_delay = $urandom_range(0, RD_TIMEOUT + 2);
            rd_val = 8'($urandom);
        end
        spur = 0;
        @(negedge clk);
        bus.rx_d_vld = 0; bus.tx_busy = 0;
        repeat (RD_TIMEOUT + 8) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
